fifo_uart_tx: RTL and testbench

Consumer end of the byte FIFO: drains queued bytes and serializes each as an 8N1 UART frame on a single `tx` line. Sits between the FIFO's read side (`data_out`, `empty`, `busy`, `pop`) and the board's UART TX pin. It issues exactly one `pop` per byte and never pops while the FIFO is busy or empty.

---
 rtl/fifo_uart_pkg.sv | 24 ++
 rtl/fifo_uart_tx_if.sv | 31 +++
 rtl/fifo_uart_tx_baud_gen.sv | 41 ++++
 rtl/fifo_uart_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_pkg.sv
// ============================================================================
// Module : fifo_uart_pkg
// Brief  : Shared FSM encoding and UART constants for the FIFO-fed UART TX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // 100 MHz system clock / 115200 baud
    localparam int   c_CLKS_PER_BIT_DEFAULT = 868;
    localparam logic c_UART_IDLE            = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
// ============================================================================
// Module : fifo_uart_tx_if
// Brief  : FIFO read-side bundle; master = byte consumer, slave = FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_busy;
    logic                  fifo_pop;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  fifo_busy,
        output fifo_pop
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        output fifo_busy,
        input  fifo_pop
    );
endinterface

`default_nettype wire

// File: rtl/fifo_uart_tx_baud_gen.sv
// ============================================================================
// Module : uart_baud_gen
// Brief  : Bit-period counter with synchronous clear and end-of-bit tick.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             clear,
    output logic                  bit_tick,
    output logic [CNT_W-1:0]      count
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // Wrap on tick so consecutive DATA bits restart without a state change
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear || bit_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bit_tick = (r_count == c_LAST);
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module : fifo_uart_tx
// Brief  : Drains a byte FIFO and serialises each byte as an 8N1 UART frame.
//          Define FIFO_UART_TX_PARITY_EN for an even-parity (8E1) frame.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
    input  wire logic       clock,
    input  wire logic       reset,
    fifo_uart_tx_if.master  fifo,
    output logic            tx,
    output logic            tx_active,
    output logic            tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);

    state_t                r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic [BIT_W-1:0]      r_bit,   w_bit_next;
    logic [CNT_W-1:0]      w_count;
    logic                  w_tick, w_clear, w_accept, w_tx_next;
    logic                  r_tx, r_active, r_done, r_pop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  r_parity, w_parity_next;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_clear),
        .bit_tick (w_tick),
        .count    (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit;
        w_accept     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!fifo.fifo_empty && !fifo.fifo_busy) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_START;
                    w_shift_next = fifo.fifo_data;
                    w_bit_next   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    w_parity_next = ^fifo.fifo_data;
`endif
                end
            end
            ST_START: begin
                if (w_tick) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit == c_LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_tick) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Outputs are registered, so the line level is derived from the next state
        w_tx_next = c_UART_IDLE;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = r_parity;
`endif
            default:   w_tx_next = c_UART_IDLE;
        endcase

        w_clear = (w_state_next != r_state) || (r_state == ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bit    <= '0;
            r_tx     <= c_UART_IDLE;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_pop    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_bit    <= w_bit_next;
            r_tx     <= w_tx_next;
            r_active <= (w_state_next != ST_IDLE);
            r_done   <= (r_state == ST_STOP) && (w_count == c_DONE_CNT);
            r_pop    <= w_accept;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    assign tx            = r_tx;
    assign tx_active     = r_active;
    assign tx_done       = r_done;
    assign fifo.fifo_pop = r_pop;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module : tb_fifo_uart_tx
// Brief  : Directed self-checking bench for fifo_uart_tx with a small FIFO model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NSEG = 11;
`else
    localparam int NSEG = 10;
`endif
    localparam int FRAME = NSEG * CPB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx, tx_active, tx_done;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) fif ();

    logic [7:0] mem [0:15];
    int   rd = 0;
    int   wr = 0;
    int   pop_count = 0;
    logic busy_pop = 1'b0;
    logic busy_force = 1'b0;

    int errors = 0;
    int checks = 0;

    logic tx_s   [0:127];
    logic act_s  [0:127];
    logic done_s [0:127];
    logic pop_s  [0:127];
    logic seg    [0:10];

    assign fif.fifo_data  = mem[rd[3:0]];
    assign fif.fifo_empty = (rd == wr);
    assign fif.fifo_busy  = busy_pop | busy_force;

    always #5 clock = ~clock;

    // FIFO reports busy for one cycle after each pop
    always @(posedge clock) begin
        busy_pop <= fif.fifo_pop;
        if (fif.fifo_pop) begin
            rd        <= rd + 1;
            pop_count <= pop_count + 1;
        end
    end

    fifo_uart_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .fifo      (fif.master),
        .tx        (tx),
        .tx_active (tx_active),
        .tx_done   (tx_done)
    );

    task automatic push(input logic [7:0] b);
        mem[wr[3:0]] = b;
        wr = wr + 1;
    endtask

    task automatic build_frame(input logic [7:0] b);
        seg[0] = 1'b0;
        for (int i = 0; i < 8; i++) seg[i+1] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
        seg[9] = ^b;
`endif
        seg[NSEG-1] = 1'b1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx_active === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clock);
            tx_s[i]   = tx;
            act_s[i]  = tx_active;
            done_s[i] = tx_done;
            pop_s[i]  = fif.fifo_pop;
        end
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL rst_tx got=%b want=1", tx); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL rst_active got=%b want=0", tx_active); end
        checks++; if (tx_done !== 1'b0)   begin errors++; $display("FAIL rst_done got=%b want=0", tx_done); end
        checks++; if (fif.fifo_pop !== 1'b0) begin errors++; $display("FAIL rst_pop got=%b want=0", fif.fifo_pop); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx got=%b want=1", tx); end
    endtask

    task automatic test_single;
        bit ok;
        int pc0 = pop_count;
        push(8'hA5);
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL a5_start got=timeout want=frame"); end
        if (ok) begin
            capture(FRAME + 1);
            build_frame(8'hA5);
            for (int i = 0; i < FRAME; i++) begin
                checks++; if (tx_s[i] !== seg[i/CPB]) begin errors++; $display("FAIL a5_tx[%0d] got=%b want=%b", i, tx_s[i], seg[i/CPB]); end
                checks++; if (done_s[i] !== (i == FRAME - 1)) begin errors++; $display("FAIL a5_done[%0d] got=%b want=%b", i, done_s[i], (i == FRAME - 1)); end
                checks++; if (act_s[i] !== 1'b1) begin errors++; $display("FAIL a5_active[%0d] got=%b want=1", i, act_s[i]); end
            end
            checks++; if (tx_s[FRAME] !== 1'b1 || act_s[FRAME] !== 1'b0) begin errors++; $display("FAIL a5_after got=tx%b/act%b want=tx1/act0", tx_s[FRAME], act_s[FRAME]); end
            checks++; if (pop_s[0] !== 1'b1 || pop_s[1] !== 1'b0) begin errors++; $display("FAIL a5_pop_pulse got=%b%b want=10", pop_s[0], pop_s[1]); end
            checks++; if (pop_count - pc0 != 1) begin errors++; $display("FAIL a5_pops got=%0d want=1", pop_count - pc0); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int pc0 = pop_count;
        push(8'h00);
        push(8'hFF);
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_start got=timeout want=frame"); end
        if (ok) begin
            capture(2 * FRAME + 2);
            build_frame(8'h00);
            for (int i = 0; i < FRAME; i++) begin
                checks++; if (tx_s[i] !== seg[i/CPB]) begin errors++; $display("FAIL b2b_tx0[%0d] got=%b want=%b", i, tx_s[i], seg[i/CPB]); end
            end
            checks++; if (tx_s[FRAME] !== 1'b1 || act_s[FRAME] !== 1'b0) begin errors++; $display("FAIL b2b_gap got=tx%b/act%b want=tx1/act0", tx_s[FRAME], act_s[FRAME]); end
            checks++; if (pop_s[FRAME+1] !== 1'b1) begin errors++; $display("FAIL b2b_pop2 got=%b want=1", pop_s[FRAME+1]); end
            build_frame(8'hFF);
            for (int i = 0; i < FRAME; i++) begin
                checks++; if (tx_s[FRAME+1+i] !== seg[i/CPB]) begin errors++; $display("FAIL b2b_tx1[%0d] got=%b want=%b", i, tx_s[FRAME+1+i], seg[i/CPB]); end
            end
            checks++; if (act_s[2*FRAME+1] !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b want=0", act_s[2*FRAME+1]); end
            checks++; if (pop_count - pc0 != 2) begin errors++; $display("FAIL b2b_pops got=%0d want=2", pop_count - pc0); end
        end
    endtask

    task automatic test_busy;
        bit found = 1'b0;
        int pc0 = pop_count;
        busy_force = 1'b1;
        push(8'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (fif.fifo_pop !== 1'b0 || tx_active !== 1'b0) begin errors++; $display("FAIL busy_hold[%0d] got=pop%b/act%b want=pop0/act0", i, fif.fifo_pop, tx_active); end
        end
        busy_force = 1'b0;
        @(negedge clock);
        checks++; if (fif.fifo_pop !== 1'b1 || tx !== 1'b0) begin errors++; $display("FAIL busy_release got=pop%b/tx%b want=pop1/tx0", fif.fifo_pop, tx); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL busy_done got=timeout want=tx_done"); end
        @(negedge clock);
        checks++; if (pop_count - pc0 != 1) begin errors++; $display("FAIL busy_pops got=%0d want=1", pop_count - pc0); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int pc0 = pop_count;
        push(8'h3C);
        push(8'h96);
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_start got=timeout want=frame"); end
        // Sample 17 lies inside data bit 3
        for (int i = 0; i < 17; i++) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL rmid_tx got=%b want=1", tx); end
        checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL rmid_active got=%b want=0", tx_active); end
        @(negedge clock);
        reset = 1'b0;
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_next got=timeout want=frame"); end
        if (ok) begin
            capture(FRAME + 1);
            build_frame(8'h96);
            for (int i = 0; i < FRAME; i++) begin
                checks++; if (tx_s[i] !== seg[i/CPB]) begin errors++; $display("FAIL rmid_tx96[%0d] got=%b want=%b", i, tx_s[i], seg[i/CPB]); end
            end
            checks++; if (act_s[FRAME] !== 1'b0) begin errors++; $display("FAIL rmid_end got=%b want=0", act_s[FRAME]); end
        end
        checks++; if (pop_count - pc0 != 2) begin errors++; $display("FAIL rmid_pops got=%0d want=2", pop_count - pc0); end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity;
        bit ok;
        push(8'h07);
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL par_start got=timeout want=frame"); end
        if (ok) begin
            capture(45);
            for (int i = 36; i < 40; i++) begin
                checks++; if (tx_s[i] !== 1'b1) begin errors++; $display("FAIL par_bit[%0d] got=%b want=1", i, tx_s[i]); end
            end
            checks++; if (done_s[43] !== 1'b1 || act_s[44] !== 1'b0) begin errors++; $display("FAIL par_len got=done%b/act%b want=done1/act0", done_s[43], act_s[44]); end
        end
    endtask
`endif

    task automatic test_empty;
        int bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || fif.fifo_pop !== 1'b0 || tx_active !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL empty_idle got=%0d bad cycles want=0", bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy();
        test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        test_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
